// File: rtl/m_lsu_bridge_if.sv
// rtl/m_lsu_bridge_if.sv - M-stage request/response and data-bus signal bundle
interface m_lsu_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  req_addr_ov;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic [1:0]            resp_exc;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_be;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_ack;
  logic [DATA_W-1:0]     bus_rdata;

  // master is the bridge itself: it serves requests and masters the data bus
  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_addr_ov,
    input  resp_ready, bus_ack, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_addr_ov,
    output resp_ready, bus_ack, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/m_lsu_bridge.sv
// rtl/m_lsu_bridge.sv - single-outstanding load/store bridge between M stage and data bus
module m_lsu_bridge #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter int          TIMEOUT = 15,
  parameter logic [31:0] DM_HI   = 32'h0000_2FFF,
  parameter logic [31:0] TMR0_LO = 32'h0000_7F00,
  parameter logic [31:0] TMR0_HI = 32'h0000_7F0B,
  parameter logic [31:0] TMR1_LO = 32'h0000_7F10,
  parameter logic [31:0] TMR1_HI = 32'h0000_7F1B,
  parameter logic [31:0] INT_LO  = 32'h0000_7F20,
  parameter logic [31:0] INT_HI  = 32'h0000_7F23
) (
  input  logic          clk,
  input  logic          reset_n,
  m_lsu_bridge_if.master lsu,
  output logic          busy
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_BYTE  = 2'b01;
  localparam logic [1:0] SZ_HALF  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic [ADDR_W-1:0] A_DM_HI   = ADDR_W'(DM_HI);
  localparam logic [ADDR_W-1:0] A_TMR0_LO = ADDR_W'(TMR0_LO);
  localparam logic [ADDR_W-1:0] A_TMR0_HI = ADDR_W'(TMR0_HI);
  localparam logic [ADDR_W-1:0] A_TMR1_LO = ADDR_W'(TMR1_LO);
  localparam logic [ADDR_W-1:0] A_TMR1_HI = ADDR_W'(TMR1_HI);
  localparam logic [ADDR_W-1:0] A_INT_LO  = ADDR_W'(INT_LO);
  localparam logic [ADDR_W-1:0] A_INT_HI  = ADDR_W'(INT_HI);
  localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [1:0]        resp_exc_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [NB-1:0]     bus_be_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [LW-1:0]     lat_lane;
  logic [1:0]        lat_size;
  logic              lat_uns;

  logic [ADDR_W-1:0] a;
  logic              misaligned, in_dm, in_t0, in_t1, in_int, tmr_err, exc_hit;
  logic [NB-1:0]     be_mask;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;

  assign a = lsu.req_addr;

  always_comb begin
    misaligned = 1'b0;
    case (lsu.req_size)
      SZ_HALF:  misaligned = a[0];
      SZ_WORD:  misaligned = |a[1:0];
      SZ_DWORD: misaligned = (DATA_W != 64) || (|a[2:0]);
      default:  misaligned = 1'b0;
    endcase
  end

  assign in_dm   = (a <= A_DM_HI);
  assign in_t0   = (a >= A_TMR0_LO) && (a <= A_TMR0_HI);
  assign in_t1   = (a >= A_TMR1_LO) && (a <= A_TMR1_HI);
  assign in_int  = (a >= A_INT_LO) && (a <= A_INT_HI);
  assign tmr_err = (lsu.req_size != SZ_WORD) && (in_t0 || in_t1);
  assign exc_hit = misaligned || !(in_dm || in_t0 || in_t1 || in_int) || tmr_err || lsu.req_addr_ov;

  // loads drive the same lane mask as stores so the slave can gate its read port
  always_comb begin
    be_mask    = '0;
    wdata_next = lsu.req_wdata;
    case (lsu.req_size)
      SZ_BYTE: begin
        be_mask    = NB'(1);
        wdata_next = {NB{lsu.req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_mask    = NB'(3);
        wdata_next = {(NB/2){lsu.req_wdata[15:0]}};
      end
      SZ_WORD: begin
        be_mask    = NB'(15);
        wdata_next = {(NB/4){lsu.req_wdata[31:0]}};
      end
      default: begin
        be_mask    = '1;
        wdata_next = lsu.req_wdata;
      end
    endcase
  end

  assign sh = lsu.bus_rdata >> {lat_lane, 3'b000};

  always_comb begin
    ext = sh;
    case (lat_size)
      SZ_BYTE: ext = lat_uns ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
      SZ_HALF: ext = lat_uns ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
      SZ_WORD: ext = lat_uns ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      resp_rdata_q <= '0;
      resp_exc_q   <= 2'b00;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      lat_lane     <= '0;
      lat_size     <= 2'b00;
      lat_uns      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu.req_valid) begin
            if (exc_hit) begin
              state        <= S_RESP;
              resp_exc_q   <= lsu.req_we ? 2'b10 : 2'b01;
              resp_rdata_q <= '0;
            end else begin
              state       <= S_BUS;
              cnt         <= 8'd0;
              bus_we_q    <= lsu.req_we;
              bus_addr_q  <= {a[ADDR_W-1:LW], {LW{1'b0}}};
              bus_be_q    <= be_mask << a[LW-1:0];
              bus_wdata_q <= wdata_next;
              lat_lane    <= a[LW-1:0];
              lat_size    <= lsu.req_size;
              lat_uns     <= lsu.req_unsigned;
            end
          end
        end
        S_BUS: begin
          // an ack in the expiry cycle still completes normally
          if (lsu.bus_ack) begin
            state        <= S_RESP;
            resp_exc_q   <= 2'b00;
            resp_rdata_q <= bus_we_q ? '0 : ext;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == TO_LAST) begin
              state        <= S_RESP;
              resp_exc_q   <= 2'b11;
              resp_rdata_q <= '0;
            end
          end
        end
        S_RESP: begin
          if (lsu.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu.req_ready  = (state == S_IDLE);
  assign lsu.resp_valid = (state == S_RESP);
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_exc   = resp_exc_q;
  assign lsu.bus_req    = (state == S_BUS);
  assign lsu.bus_we     = bus_we_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_be     = bus_be_q;
  assign lsu.bus_wdata  = bus_wdata_q;
  assign busy           = (state != S_IDLE);
endmodule

// File: tb/tb_m_lsu_bridge.sv
// tb/tb_m_lsu_bridge.sv - directed bench for m_lsu_bridge (32-bit TIMEOUT=3 and 64-bit instances)
module tb_m_lsu_bridge;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy32, busy64;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  m_lsu_bridge_if #(.DATA_W(32), .ADDR_W(32)) i32 ();
  m_lsu_bridge_if #(.DATA_W(64), .ADDR_W(32)) i64 ();

  m_lsu_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(3)) d32 (.clk(clk), .reset_n(reset_n), .lsu(i32), .busy(busy32));
  m_lsu_bridge #(.DATA_W(64), .ADDR_W(32)) d64 (.clk(clk), .reset_n(reset_n), .lsu(i64), .busy(busy64));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic ov);
    i32.req_we = we; i32.req_size = size; i32.req_unsigned = uns;
    i32.req_addr = addr; i32.req_wdata = wdata; i32.req_addr_ov = ov;
    i32.req_valid = 1'b1;
    step();
    i32.req_valid = 1'b0; i32.req_addr_ov = 1'b0;
  endtask

  task automatic start64(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    i64.req_we = 1'b0; i64.req_size = size; i64.req_unsigned = uns;
    i64.req_addr = addr; i64.req_wdata = '0; i64.req_addr_ov = 1'b0;
    i64.req_valid = 1'b1;
    step();
    i64.req_valid = 1'b0;
  endtask

  task automatic release32();
    i32.resp_ready = 1'b1;
    step();
    i32.resp_ready = 1'b0;
  endtask

  task automatic release64();
    i64.resp_ready = 1'b1;
    step();
    i64.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (i32.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%h exp=1", i32.req_ready); end
    total++; if (i32.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%h exp=0", i32.resp_valid); end
    total++; if (i32.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h exp=0", i32.resp_rdata); end
    total++; if (i32.resp_exc !== 2'b00) begin bad++; $display("FAIL reset_resp_exc got=%b exp=00", i32.resp_exc); end
    total++; if (i32.bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%h exp=0", i32.bus_req); end
    total++; if (i32.bus_we !== 1'b0) begin bad++; $display("FAIL reset_bus_we got=%h exp=0", i32.bus_we); end
    total++; if (i32.bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got=%h exp=0", i32.bus_addr); end
    total++; if (i32.bus_be !== 4'h0) begin bad++; $display("FAIL reset_bus_be got=%h exp=0", i32.bus_be); end
    total++; if (i32.bus_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus_wdata got=%h exp=0", i32.bus_wdata); end
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL reset_busy32 got=%h exp=0", busy32); end
    total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL reset_busy64 got=%h exp=0", busy64); end
    total++; if (i64.bus_be !== 8'h00) begin bad++; $display("FAIL reset_bus_be64 got=%h exp=00", i64.bus_be); end
    #10;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_lb_signed();
    start32(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 1'b0);
    total++; if (i32.bus_req !== 1'b1) begin bad++; $display("FAIL lb_bus_req_c1 got=%h exp=1", i32.bus_req); end
    total++; if (i32.bus_be !== 4'b1000) begin bad++; $display("FAIL lb_bus_be got=%b exp=1000", i32.bus_be); end
    total++; if (i32.bus_addr !== 32'h0) begin bad++; $display("FAIL lb_bus_addr got=%h exp=0", i32.bus_addr); end
    total++; if (i32.bus_we !== 1'b0) begin bad++; $display("FAIL lb_bus_we got=%h exp=0", i32.bus_we); end
    total++; if (i32.req_ready !== 1'b0) begin bad++; $display("FAIL lb_req_ready_busy got=%h exp=0", i32.req_ready); end
    step();
    total++; if (i32.bus_req !== 1'b1) begin bad++; $display("FAIL lb_bus_req_c2 got=%h exp=1", i32.bus_req); end
    step();
    total++; if (i32.resp_valid !== 1'b0) begin bad++; $display("FAIL lb_resp_valid_c3 got=%h exp=0", i32.resp_valid); end
    i32.bus_ack = 1'b1; i32.bus_rdata = 32'h80FF_1234;
    step();
    i32.bus_ack = 1'b0;
    total++; if (i32.resp_valid !== 1'b1) begin bad++; $display("FAIL lb_resp_valid_c4 got=%h exp=1", i32.resp_valid); end
    total++; if (i32.resp_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", i32.resp_rdata); end
    total++; if (i32.resp_exc !== 2'b00) begin bad++; $display("FAIL lb_exc got=%b exp=00", i32.resp_exc); end
    total++; if (i32.bus_req !== 1'b0) begin bad++; $display("FAIL lb_bus_req_resp got=%h exp=0", i32.bus_req); end
    release32();
    total++; if (i32.req_ready !== 1'b1) begin bad++; $display("FAIL lb_req_ready_after got=%h exp=1", i32.req_ready); end
    total++; if (i32.resp_valid !== 1'b0) begin bad++; $display("FAIL lb_resp_valid_after got=%h exp=0", i32.resp_valid); end
  endtask

  task automatic test_lhu();
    start32(1'b0, 2'b10, 1'b1, 32'h0000_0002, 32'h0, 1'b0);
    total++; if (i32.bus_be !== 4'b1100) begin bad++; $display("FAIL lhu_bus_be got=%b exp=1100", i32.bus_be); end
    i32.bus_ack = 1'b1; i32.bus_rdata = 32'h9ABC_0000;
    step();
    i32.bus_ack = 1'b0;
    total++; if (i32.resp_valid !== 1'b1) begin bad++; $display("FAIL lhu_resp_valid got=%h exp=1", i32.resp_valid); end
    total++; if (i32.resp_rdata !== 32'h0000_9ABC) begin bad++; $display("FAIL lhu_rdata got=%h exp=00009abc", i32.resp_rdata); end
    release32();
  endtask

  task automatic test_exceptions();
    logic        we [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [9] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01};
    logic [31:0] ad [9] = '{32'h6, 32'h7F04, 32'h3000, 32'h7F20, 32'h7F00, 32'h2FFC, 32'h0, 32'h7F0C, 32'h7F23};
    logic        ov [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        eb [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  ee [9] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 9; i++) begin
      start32(we[i], sz[i], 1'b0, ad[i], 32'h0, ov[i]);
      total++; if (i32.bus_req !== eb[i]) begin bad++; $display("FAIL exc%0d_bus_req got=%h exp=%h", i, i32.bus_req, eb[i]); end
      total++; if (i32.resp_valid !== !eb[i]) begin bad++; $display("FAIL exc%0d_resp_valid_c1 got=%h exp=%h", i, i32.resp_valid, !eb[i]); end
      if (eb[i]) begin
        i32.bus_ack = 1'b1; i32.bus_rdata = 32'h0;
        step();
        i32.bus_ack = 1'b0;
      end
      total++; if (i32.resp_valid !== 1'b1) begin bad++; $display("FAIL exc%0d_resp_valid got=%h exp=1", i, i32.resp_valid); end
      total++; if (i32.resp_exc !== ee[i]) begin bad++; $display("FAIL exc%0d_code got=%b exp=%b", i, i32.resp_exc, ee[i]); end
      total++; if (i32.resp_rdata !== 32'h0) begin bad++; $display("FAIL exc%0d_rdata got=%h exp=0", i, i32.resp_rdata); end
      release32();
    end
  endtask

  task automatic test_store_byte();
    start32(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_00AB, 1'b0);
    total++; if (i32.bus_req !== 1'b1) begin bad++; $display("FAIL sb_bus_req got=%h exp=1", i32.bus_req); end
    total++; if (i32.bus_be !== 4'b0010) begin bad++; $display("FAIL sb_bus_be got=%b exp=0010", i32.bus_be); end
    total++; if (i32.bus_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=abababab", i32.bus_wdata); end
    total++; if (i32.bus_we !== 1'b1) begin bad++; $display("FAIL sb_bus_we got=%h exp=1", i32.bus_we); end
    i32.bus_ack = 1'b1; i32.bus_rdata = 32'hFFFF_FFFF;
    step();
    i32.bus_ack = 1'b0;
    total++; if (i32.resp_exc !== 2'b00) begin bad++; $display("FAIL sb_exc got=%b exp=00", i32.resp_exc); end
    total++; if (i32.resp_rdata !== 32'h0) begin bad++; $display("FAIL sb_rdata got=%h exp=0", i32.resp_rdata); end
    release32();
  endtask

  task automatic test_timeout();
    start32(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      total++; if (i32.bus_req !== 1'b1) begin bad++; $display("FAIL to_bus_req_c%0d got=%h exp=1", c, i32.bus_req); end
      step();
    end
    total++; if (i32.bus_req !== 1'b0) begin bad++; $display("FAIL to_bus_req_drop got=%h exp=0", i32.bus_req); end
    total++; if (i32.resp_valid !== 1'b1) begin bad++; $display("FAIL to_resp_valid got=%h exp=1", i32.resp_valid); end
    total++; if (i32.resp_exc !== 2'b11) begin bad++; $display("FAIL to_exc got=%b exp=11", i32.resp_exc); end
    release32();
    start32(1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    step();
    step();
    i32.bus_ack = 1'b1; i32.bus_rdata = 32'h1234_5678;
    step();
    i32.bus_ack = 1'b0;
    total++; if (i32.resp_valid !== 1'b1) begin bad++; $display("FAIL to_ack3_valid got=%h exp=1", i32.resp_valid); end
    total++; if (i32.resp_exc !== 2'b00) begin bad++; $display("FAIL to_ack3_exc got=%b exp=00", i32.resp_exc); end
    total++; if (i32.resp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL to_ack3_rdata got=%h exp=12345678", i32.resp_rdata); end
    release32();
  endtask

  task automatic test_back_to_back();
    start32(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
    i32.bus_ack = 1'b1; i32.bus_rdata = 32'hFEDC_0000;
    step();
    for (int c = 0; c < 5; c++) begin
      i32.bus_ack = 1'b1; i32.bus_rdata = 32'h1111_1111;
      total++; if (i32.resp_valid !== 1'b1) begin bad++; $display("FAIL hold%0d_valid got=%h exp=1", c, i32.resp_valid); end
      total++; if (i32.resp_rdata !== 32'hFFFF_FEDC) begin bad++; $display("FAIL hold%0d_rdata got=%h exp=fffffedc", c, i32.resp_rdata); end
      total++; if (i32.req_ready !== 1'b0) begin bad++; $display("FAIL hold%0d_req_ready got=%h exp=0", c, i32.req_ready); end
      step();
    end
    i32.bus_ack = 1'b0;
    total++; if (i32.resp_rdata !== 32'hFFFF_FEDC) begin bad++; $display("FAIL hold_rdata_final got=%h exp=fffffedc", i32.resp_rdata); end
    i32.resp_ready = 1'b1;
    i32.req_we = 1'b0; i32.req_size = 2'b00; i32.req_unsigned = 1'b0; i32.req_addr = 32'h0; i32.req_valid = 1'b1;
    step();
    i32.resp_ready = 1'b0;
    total++; if (i32.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_req_ready got=%h exp=1", i32.req_ready); end
    total++; if (i32.bus_req !== 1'b0) begin bad++; $display("FAIL b2b_no_same_cycle got=%h exp=0", i32.bus_req); end
    step();
    i32.req_valid = 1'b0;
    total++; if (i32.bus_req !== 1'b1) begin bad++; $display("FAIL b2b_bus_req got=%h exp=1", i32.bus_req); end
    total++; if (i32.bus_be !== 4'hF) begin bad++; $display("FAIL b2b_bus_be got=%h exp=f", i32.bus_be); end
    i32.bus_ack = 1'b1; i32.bus_rdata = 32'hCAFE_F00D;
    step();
    i32.bus_ack = 1'b0;
    total++; if (i32.resp_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_rdata got=%h exp=cafef00d", i32.resp_rdata); end
    release32();
  endtask

  task automatic test_reset_mid();
    start32(1'b0, 2'b00, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    total++; if (i32.bus_addr !== 32'h8) begin bad++; $display("FAIL rst_mid_addr_pre got=%h exp=8", i32.bus_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (i32.bus_req !== 1'b0) begin bad++; $display("FAIL rst_mid_bus_req got=%h exp=0", i32.bus_req); end
    total++; if (i32.bus_addr !== 32'h0) begin bad++; $display("FAIL rst_mid_bus_addr got=%h exp=0", i32.bus_addr); end
    total++; if (i32.bus_be !== 4'h0) begin bad++; $display("FAIL rst_mid_bus_be got=%h exp=0", i32.bus_be); end
    total++; if (i32.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_req_ready got=%h exp=1", i32.req_ready); end
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%h exp=0", busy32); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    total++; if (i32.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_no_resp got=%h exp=0", i32.resp_valid); end
    total++; if (i32.bus_req !== 1'b0) begin bad++; $display("FAIL rst_mid_idle_bus got=%h exp=0", i32.bus_req); end
  endtask

  task automatic test_dword64();
    start64(2'b11, 1'b0, 32'h0000_0008);
    total++; if (i64.bus_be !== 8'hFF) begin bad++; $display("FAIL ld_bus_be got=%h exp=ff", i64.bus_be); end
    total++; if (i64.bus_addr !== 32'h8) begin bad++; $display("FAIL ld_bus_addr got=%h exp=8", i64.bus_addr); end
    i64.bus_ack = 1'b1; i64.bus_rdata = 64'h8877_6655_4433_2211;
    step();
    i64.bus_ack = 1'b0;
    total++; if (i64.resp_rdata !== 64'h8877_6655_4433_2211) begin bad++; $display("FAIL ld_rdata got=%h exp=8877665544332211", i64.resp_rdata); end
    release64();
    start64(2'b00, 1'b0, 32'h0000_000C);
    total++; if (i64.bus_be !== 8'hF0) begin bad++; $display("FAIL lw64_bus_be got=%h exp=f0", i64.bus_be); end
    total++; if (i64.bus_addr !== 32'h8) begin bad++; $display("FAIL lw64_bus_addr got=%h exp=8", i64.bus_addr); end
    i64.bus_ack = 1'b1; i64.bus_rdata = 64'h8000_0000_0000_0000;
    step();
    i64.bus_ack = 1'b0;
    total++; if (i64.resp_rdata !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL lw64_rdata got=%h exp=ffffffff80000000", i64.resp_rdata); end
    release64();
    start64(2'b00, 1'b1, 32'h0000_000C);
    i64.bus_ack = 1'b1; i64.bus_rdata = 64'h8000_0000_0000_0000;
    step();
    i64.bus_ack = 1'b0;
    total++; if (i64.resp_rdata !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL lwu64_rdata got=%h exp=0000000080000000", i64.resp_rdata); end
    release64();
    start64(2'b11, 1'b0, 32'h0000_0004);
    total++; if (i64.bus_req !== 1'b0) begin bad++; $display("FAIL ld_mis_bus_req got=%h exp=0", i64.bus_req); end
    total++; if (i64.resp_exc !== 2'b01) begin bad++; $display("FAIL ld_mis_exc got=%b exp=01", i64.resp_exc); end
    release64();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    i32.req_valid = 1'b0; i32.req_we = 1'b0; i32.req_size = 2'b00; i32.req_unsigned = 1'b0;
    i32.req_addr = '0; i32.req_wdata = '0; i32.req_addr_ov = 1'b0; i32.resp_ready = 1'b0;
    i32.bus_ack = 1'b0; i32.bus_rdata = '0;
    i64.req_valid = 1'b0; i64.req_we = 1'b0; i64.req_size = 2'b00; i64.req_unsigned = 1'b0;
    i64.req_addr = '0; i64.req_wdata = '0; i64.req_addr_ov = 1'b0; i64.resp_ready = 1'b0;
    i64.bus_ack = 1'b0; i64.bus_rdata = '0;
    test_reset();
    test_lb_signed();
    test_lhu();
    test_exceptions();
    test_store_byte();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_dword64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m_lsu_bridge.md
Name: m_lsu_bridge

Overview:
- Parametrised successor to the M-stage DM load extractor: a single-outstanding load/store unit between the M stage and the data bus.
- Checks alignment, address map and timer-width rules, and raises AdEL or AdES before any bus access.
- Issues a handshaked bus transaction with byte enables, then extracts and extends load data (sign or zero) on return.
- Adds stores, unsigned loads, a bus wait-state handshake and a timeout bus-error, none of which the combinational extractor had.

Parameters:
DATA_W, 32, bus/data width; legal values 32 or 64 (64 enables doubleword size)
ADDR_W, 32, address width
TIMEOUT, 15, max cycles waiting for bus_ack before a bus error (1..255)
DM_HI, 32'h0000_2FFF, top of DM region (DM base is 0)
TMR0_LO/TMR0_HI, 32'h7F00/32'h7F0B, timer 0 window
TMR1_LO/TMR1_HI, 32'h7F10/32'h7F1B, timer 1 window
INT_LO/INT_HI, 32'h7F20/32'h7F23, interrupt generator window

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  M-stage memory request
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 byte, 10 half, 11 dword (legal only when DATA_W=64)
req_unsigned  in  1  zero-extend load (lbu/lhu)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
req_addr_ov  in  1  address-computation overflow flagged upstream
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_rdata  out  DATA_W  extended load data (0 for stores and exceptions)
resp_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus error
bus_req  out  1  bus transaction pending
bus_we  out  1  bus write
bus_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared
bus_be  out  DATA_W/8  byte enables
bus_wdata  out  DATA_W  store data replicated into lane position
bus_ack  in  1  bus completion; bus_rdata valid in the same cycle
bus_rdata  in  DATA_W  read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_exc=00, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, timeout counter=0. Reset mid-transaction aborts it with no response.
- States are IDLE, BUS and RESP. req_ready=1 only in IDLE.
- Exception check, evaluated at acceptance:
  - Misaligned if half has addr[0]=1, word has addr[1:0]!=0, or dword has addr[2:0]!=0.
  - Out-of-range if the address is outside [0,DM_HI], all timer windows and the INT window.
  - Timer error if size!=word and the address is inside a timer window.
  - size=11 with DATA_W=32 counts as misaligned.
  - exc = misaligned | out-of-range | timer error | req_addr_ov. A load gives 01, a store gives 10.
- IDLE, on accept:
  - Exception present: go to RESP with resp_exc set; no bus activity.
  - Otherwise: go to BUS, latch the request, drive bus_req=1, bus_addr, bus_be and bus_wdata from registers.
  - Total latency from accept to resp_valid is at least 2 cycles.
- bus_be lane rule (lane = addr low bits):
  - byte: one bit at lane.
  - half: two bits at lane.
  - word: four bits at lane (lane is 0 or 4 for 64-bit).
  - dword: all bits set.
  - bus_be=0 for loads is not allowed; loads drive the same mask.
- BUS:
  - bus_req is held until bus_ack. On bus_ack, capture the extracted load data and go to RESP with exc=00.
  - The timeout counter increments each BUS cycle without ack. When it reaches TIMEOUT: drop bus_req, resp_exc=11, go to RESP.
  - A bus_ack arriving in the same cycle as expiry wins (normal response).
- Extraction: select the lane by address. Sign-extend from the top bit of the field unless req_unsigned, then zero-extend. Word on 64-bit follows the same rule. Stores return resp_rdata=0.
- RESP:
  - resp_valid=1, and resp_rdata and resp_exc are stable until resp_ready.
  - On resp_valid & resp_ready: return to IDLE; req_ready rises the next cycle. No same-cycle re-accept.
- bus_ack outside BUS is ignored.

Test Plan:
- lb at addr 0x0000_0003, bus_rdata=0x80FF_1234, ack after 2 wait cycles -> bus_be=4'b1000, resp_rdata=0xFFFF_FF80, exc=00, response 4 cycles after accept.
- lhu at 0x0000_0002, bus_rdata=0x9ABC_0000 -> bus_be=4'b1100, resp_rdata=0x0000_9ABC.
- sw at 0x0000_0006 -> no bus_req, resp_exc=10 next cycle. lh at 0x7F04 -> resp_exc=01. lw at 0x3000 -> exc=01. sw at 0x7F20 -> bus_req, exc=00.
- sb at 0x0000_0001, wdata=0x0000_00AB -> bus_be=4'b0010, bus_wdata=0xABAB_ABAB, bus_we=1, exc=00 on ack.
- TIMEOUT=3, no ack -> bus_req drops after 3 BUS cycles, exc=11. Repeat with ack on cycle 3 -> normal data.
- resp_ready held low 5 cycles -> response stable, req_ready=0. Deassert reset_n while in BUS -> all outputs at reset values immediately. DATA_W=64 ld at 0x8 -> bus_be=8'hFF.
